// File: rtl/cpu_pkg.sv
// Shared definitions for the fetch front end: next-PC select codes,
// fetch FSM states and the instruction word size.
package cpu_pkg;

  typedef enum logic [1:0] {
    PC_SEQ    = 2'b00,
    PC_BRANCH = 2'b01,
    PC_JUMP   = 2'b10,
    PC_REG    = 2'b11
  } pcsrc_e;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_FETCH = 1'b1
  } fetch_state_e;

  localparam int unsigned WORD_BYTES = 4;

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Instruction-memory read handshake: req/addr toward memory, ack/rdata back.
interface pc_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
  modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);
endinterface

// File: rtl/pc_fetch_unit_next_pc_sel.sv
// Combinational next-PC selection: sequential, branch, jump and register targets.
module next_pc_sel
  import cpu_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [1:0]  PCSrc,
  input  logic [31:0] immExt,
  input  logic [25:0] jumpAddr,
  input  logic [31:0] regAddr,
  output logic [31:0] next_pc,
  output logic [31:0] pc_plus4
);

  // All adds wrap modulo 2^32; the word-offset shift drops immExt[31:30].
  always_comb begin
    pc_plus4 = pc + 32'(WORD_BYTES);
    case (PCSrc)
      PC_SEQ:    next_pc = pc_plus4;
      PC_BRANCH: next_pc = pc_plus4 + (immExt << 2);
      PC_JUMP:   next_pc = {pc_plus4[31:28], jumpAddr, 2'b00};
      default:   next_pc = regAddr;
    endcase
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// PC register and instruction-fetch front end with req/ack memory handshake.
module pc_fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   PCWre,
  input  logic [1:0]             PCSrc,
  input  logic [31:0]            immExt,
  input  logic [25:0]            jumpAddr,
  input  logic [31:0]            regAddr,
  input  logic                   fetch_start,
  pc_fetch_unit_if.master        imem,
  output logic [31:0]            pc,
  output logic [31:0]            pc_plus4,
  output logic [31:0]            IR,
  output logic                   ir_valid,
  output logic                   busy,
  output logic                   pc_misaligned
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, next_pc, pend_pc_q, ir_q, addr_q, fetch_pc, commit_val;
  logic         pend_valid_q, req_q, ir_valid_q, mis_q;
  logic         start_fetch, fetch_done, commit_en, pend_load;

  next_pc_sel u_sel (
    .pc       (pc_q),
    .PCSrc    (PCSrc),
    .immExt   (immExt),
    .jumpAddr (jumpAddr),
    .regAddr  (regAddr),
    .next_pc  (next_pc),
    .pc_plus4 (pc_plus4)
  );

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next state, fetch launch/completion and PC commit decisions.
  // A PCWre on the ack edge itself is the newest update, so it beats the pending value.
  always_comb begin
    state_d     = state_q;
    start_fetch = 1'b0;
    fetch_done  = 1'b0;
    commit_en   = 1'b0;
    commit_val  = next_pc;
    pend_load   = 1'b0;
    fetch_pc    = PCWre ? next_pc : pc_q;
    case (state_q)
      S_IDLE: begin
        commit_en = PCWre;
        if (fetch_start) begin
          state_d     = S_FETCH;
          start_fetch = 1'b1;
        end
      end
      default: begin
        if (imem.imem_ack) begin
          state_d    = S_IDLE;
          fetch_done = 1'b1;
          if (PCWre) begin
            commit_en = 1'b1;
          end else if (pend_valid_q) begin
            commit_en  = 1'b1;
            commit_val = pend_pc_q;
          end
        end else begin
          pend_load = PCWre;
        end
      end
    endcase
  end

  // PC, pending PC, request/address, IR and sticky misalignment flag.
  always_ff @(posedge CLK) begin
    if (RST) begin
      pc_q         <= RESET_PC;
      pend_pc_q    <= '0;
      pend_valid_q <= 1'b0;
      ir_q         <= '0;
      ir_valid_q   <= 1'b0;
      req_q        <= 1'b0;
      addr_q       <= '0;
      mis_q        <= 1'b0;
    end else begin
      ir_valid_q <= fetch_done;
      if (commit_en) begin
        pc_q <= commit_val;
        if (commit_val[1:0] != 2'b00) mis_q <= 1'b1;
      end
      if (pend_load) begin
        pend_pc_q    <= next_pc;
        pend_valid_q <= 1'b1;
      end else if (fetch_done) begin
        pend_valid_q <= 1'b0;
      end
      if (start_fetch) begin
        req_q  <= 1'b1;
        addr_q <= {fetch_pc[31:2], 2'b00};
      end else if (fetch_done) begin
        req_q <= 1'b0;
      end
      if (fetch_done) ir_q <= imem.imem_rdata;
    end
  end

  assign imem.imem_req  = req_q;
  assign imem.imem_addr = addr_q;
  assign pc             = pc_q;
  assign IR             = ir_q;
  assign ir_valid       = ir_valid_q;
  assign busy           = (state_q == S_FETCH);
  assign pc_misaligned  = mis_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit with hand-computed expected values.
module tb_pc_fetch_unit;

  logic        CLK = 1'b0;
  logic        RST;
  logic        PCWre;
  logic [1:0]  PCSrc;
  logic [31:0] immExt;
  logic [25:0] jumpAddr;
  logic [31:0] regAddr;
  logic        fetch_start;
  logic [31:0] pc, pc_plus4, IR;
  logic        ir_valid, busy, pc_misaligned;

  int unsigned errors = 0;
  int unsigned checks = 0;

  pc_fetch_unit_if imem ();

  pc_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .CLK           (CLK),
    .RST           (RST),
    .PCWre         (PCWre),
    .PCSrc         (PCSrc),
    .immExt        (immExt),
    .jumpAddr      (jumpAddr),
    .regAddr       (regAddr),
    .fetch_start   (fetch_start),
    .imem          (imem),
    .pc            (pc),
    .pc_plus4      (pc_plus4),
    .IR            (IR),
    .ir_valid      (ir_valid),
    .busy          (busy),
    .pc_misaligned (pc_misaligned)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs are changed and outputs sampled 1 time unit after it.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic load_pc(input logic [31:0] v);
    PCSrc   = 2'b11;
    regAddr = v;
    PCWre   = 1'b1;
    tick();
    PCWre   = 1'b0;
  endtask

  initial begin
    RST = 1'b1; PCWre = 1'b0; PCSrc = 2'b00; immExt = '0; jumpAddr = '0;
    regAddr = '0; fetch_start = 1'b0;
    imem.imem_ack = 1'b0; imem.imem_rdata = '0;
    tick(); tick();
    check("rst_pc", pc, 32'h0);
    check("rst_ir", IR, 32'h0);
    check("rst_irv", {31'b0, ir_valid}, 32'h0);
    check("rst_req", {31'b0, imem.imem_req}, 32'h0);
    check("rst_addr", imem.imem_addr, 32'h0);
    check("rst_busy", {31'b0, busy}, 32'h0);
    check("rst_mis", {31'b0, pc_misaligned}, 32'h0);
    RST = 1'b0;

    // First fetch, ack three cycles after the request appears.
    fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0;
    check("f1_req", {31'b0, imem.imem_req}, 32'h1);
    check("f1_addr", imem.imem_addr, 32'h0);
    check("f1_busy", {31'b0, busy}, 32'h1);
    tick(); tick();
    check("f1_hold", {31'b0, imem.imem_req}, 32'h1);
    imem.imem_ack = 1'b1; imem.imem_rdata = 32'h2001_0005;
    tick();
    imem.imem_ack = 1'b0; imem.imem_rdata = '0;
    check("f1_ir", IR, 32'h2001_0005);
    check("f1_irv", {31'b0, ir_valid}, 32'h1);
    check("f1_req_lo", {31'b0, imem.imem_req}, 32'h0);
    check("f1_pc", pc, 32'h0);
    tick();
    check("f1_irv_pulse", {31'b0, ir_valid}, 32'h0);
    check("f1_ir_hold", IR, 32'h2001_0005);

    // Sequential wrap.
    load_pc(32'hFFFF_FFFC);
    check("wrap_p4", pc_plus4, 32'h0);
    PCSrc = 2'b00; PCWre = 1'b1; tick(); PCWre = 1'b0;
    check("wrap_pc", pc, 32'h0);

    // Branch backwards by two words.
    load_pc(32'h10);
    PCSrc = 2'b01; immExt = 32'hFFFF_FFFE; PCWre = 1'b1; tick(); PCWre = 1'b0;
    check("branch_pc", pc, 32'h0000_000C);

    // Jump.
    load_pc(32'h10);
    PCSrc = 2'b10; jumpAddr = 26'h000_0040; PCWre = 1'b1; tick(); PCWre = 1'b0;
    check("jump_pc", pc, 32'h0000_0100);
    check("mis_still0", {31'b0, pc_misaligned}, 32'h0);

    // Register target, misaligned.
    load_pc(32'h0000_0203);
    check("jr_pc", pc, 32'h0000_0203);
    check("jr_mis", {31'b0, pc_misaligned}, 32'h1);
    fetch_start = 1'b1; tick(); fetch_start = 1'b0;
    check("jr_addr", imem.imem_addr, 32'h0000_0200);
    imem.imem_ack = 1'b1; imem.imem_rdata = 32'h1111_2222; tick(); imem.imem_ack = 1'b0;
    check("jr_ir", IR, 32'h1111_2222);

    // PCWre while fetching: deferred to the ack edge.
    load_pc(32'h40);
    check("mis_sticky", {31'b0, pc_misaligned}, 32'h1);
    fetch_start = 1'b1; tick(); fetch_start = 1'b0;
    check("pend_addr", imem.imem_addr, 32'h40);
    PCSrc = 2'b00; PCWre = 1'b1; tick(); PCWre = 1'b0;
    check("pend_pc_a", pc, 32'h40);
    tick();
    check("pend_pc_b", pc, 32'h40);
    imem.imem_ack = 1'b1; tick(); imem.imem_ack = 1'b0;
    check("pend_commit", pc, 32'h44);

    // Two updates while fetching: last one wins.
    fetch_start = 1'b1; tick(); fetch_start = 1'b0;
    check("pend2_addr", imem.imem_addr, 32'h44);
    PCSrc = 2'b00; PCWre = 1'b1; tick();
    PCSrc = 2'b11; regAddr = 32'h80; tick(); PCWre = 1'b0;
    check("pend2_hold", pc, 32'h44);
    imem.imem_ack = 1'b1; tick(); imem.imem_ack = 1'b0;
    check("pend2_commit", pc, 32'h80);

    // Simultaneous fetch_start and PCWre in IDLE; extra starts while busy ignored.
    load_pc(32'h8);
    PCSrc = 2'b00; PCWre = 1'b1; fetch_start = 1'b1; tick(); PCWre = 1'b0;
    check("sim_addr", imem.imem_addr, 32'h0000_000C);
    check("sim_pc", pc, 32'h0000_000C);
    tick(); tick();
    check("sim_busy", {31'b0, busy}, 32'h1);
    check("sim_addr_hold", imem.imem_addr, 32'h0000_000C);
    imem.imem_ack = 1'b1; imem.imem_rdata = 32'hCAFE_0001; tick();
    imem.imem_ack = 1'b0; fetch_start = 1'b0;
    check("sim_req_lo", {31'b0, imem.imem_req}, 32'h0);
    check("sim_busy_lo", {31'b0, busy}, 32'h0);
    tick();
    check("sim_no_queue", {31'b0, imem.imem_req}, 32'h0);

    // Reset in the same cycle as an ack.
    fetch_start = 1'b1; tick(); fetch_start = 1'b0;
    RST = 1'b1; imem.imem_ack = 1'b1; imem.imem_rdata = 32'hDEAD_BEEF; tick();
    RST = 1'b0; imem.imem_ack = 1'b0;
    check("rack_ir", IR, 32'h0);
    check("rack_irv", {31'b0, ir_valid}, 32'h0);
    check("rack_req", {31'b0, imem.imem_req}, 32'h0);
    check("rack_pc", pc, 32'h0);
    check("rack_busy", {31'b0, busy}, 32'h0);
    check("rack_mis", {31'b0, pc_misaligned}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pc_fetch_unit.md
# pc_fetch_unit

Program-counter register and instruction-fetch front end of the multicycle CPU. Holds the architectural PC, computes the next PC from the control unit's PCSrc selection, and commits it on PCWre. On request it fetches the word at PC from instruction memory through a req/ack handshake and latches it into the instruction register (IR). It sits upstream of the PC incrementer/decoder path and downstream of the control unit.

## Interface
- RESET_PC, 32'h0000_0000: PC value after reset.
- CLK  in  1  clock; all state changes on the rising edge.
- RST  in  1  synchronous, active-high reset.
- PCWre  in  1  commit the next PC at this edge.
- PCSrc  in  2  next-PC select:
  - 00: PC+4
  - 01: PC+4+(immExt<<2)
  - 10: {PC+4[31:28], jumpAddr, 2'b00}
  - 11: regAddr
- immExt  in  32  sign-extended branch offset, in words.
- jumpAddr  in  26  J-type target field.
- regAddr  in  32  jr target.
- fetch_start  in  1  request a fetch at the current PC.
- imem_req  out  1  memory read request.
- imem_addr  out  32  word-aligned read address.
- imem_ack  in  1  single-cycle acknowledge; imem_rdata is valid in this cycle.
- imem_rdata  in  32  fetched word.
- pc  out  32  current PC.
- pc_plus4  out  32  PC+4, combinational.
- IR  out  32  instruction register.
- ir_valid  out  1  one-cycle pulse when IR is updated.
- busy  out  1  high while a fetch is outstanding.
- pc_misaligned  out  1  sticky; set when a committed next PC has bits [1:0] ≠ 0.

## Operation
- States: IDLE, FETCH.
- IDLE:
  - fetch_start → FETCH. At the same edge, register imem_req=1 and imem_addr = (PCWre ? next_pc : pc) with bits [1:0] forced to 00.
  - When fetch_start and PCWre are both high, the fetch uses the newly committed PC.
- FETCH:
  - imem_req and imem_addr are held stable until imem_ack.
  - On imem_ack: IR ← imem_rdata, ir_valid=1 next cycle, imem_req=0, → IDLE.
- PCWre:
  - In IDLE: pc ← next_pc at this edge.
  - In FETCH: next_pc is captured into a one-deep pending register and committed at the ack edge.
  - A second PCWre while pending is set overwrites the pending value (last wins).
- fetch_start in FETCH is ignored; no queuing.
- Arithmetic:
  - All adds are 32-bit modulo 2^32, so 32'hFFFF_FFFC + 4 = 0.
  - The branch offset shift discards the top 2 bits of immExt.
- Misalignment:
  - next_pc with bits [1:0] ≠ 0 is still stored in pc unmodified and sets pc_misaligned.
  - Only imem_addr has its low bits masked.
  - pc_misaligned clears only on RST.
- Reset values: pc=RESET_PC, IR=0, ir_valid=0, imem_req=0, imem_addr=0, busy=0, pc_misaligned=0, pending cleared, state IDLE.
- Reset mid-fetch: the request is dropped at the reset edge, and an imem_ack in the reset cycle is ignored (IR stays 0).

## Timing
- PCWre sampled at edge n → new pc visible in cycle n+1.
- fetch_start at edge n → imem_req high from cycle n+1.
- Minimum fetch latency: imem_ack in cycle n+1 → IR and ir_valid visible in cycle n+2, and fetch_start is accepted again in cycle n+2.
- busy = (state == FETCH), registered.
- ir_valid is high for exactly one cycle per completed fetch.
- No combinational path from imem_ack to imem_req or imem_addr.

## Structure
- Shared package cpu_pkg:
  - PCSrc encodings PC_SEQ, PC_BRANCH, PC_JUMP, PC_REG.
  - Fetch state enum.
  - Constant WORD_BYTES = 4.
- One sub-module next_pc_sel: combinational next-PC mux/adders, with inputs pc, PCSrc, immExt, jumpAddr, regAddr and outputs next_pc, pc_plus4.
- The FSM, PC register, pending register and IR stay in pc_fetch_unit.

## Test plan
- Reset then fetch: RST for 2 cycles, fetch_start, ack after 3 cycles with rdata=32'h2001_0005 → imem_addr=0, IR=32'h2001_0005, ir_valid pulse, pc=0.
- Sequential and wrap: pc=32'hFFFF_FFFC, PCSrc=00, PCWre → pc=0.
- Branch/jump/jr:
  - pc=32'h0000_0010, immExt=32'hFFFF_FFFE, PCSrc=01 → pc=32'h0000_000C.
  - pc=32'h0000_0010, jumpAddr=26'h000_0040, PCSrc=10 → pc=32'h0000_0100.
  - regAddr=32'h0000_0203, PCSrc=11 → pc=32'h0000_0203, pc_misaligned=1, next fetch imem_addr=32'h0000_0200.
- PCWre during FETCH: fetch at 32'h40, PCWre with PC+4 two cycles before ack → pc stays 32'h40 until the ack edge, then 32'h44. A second PCWre before ack (PCSrc=11, regAddr=32'h80) → pc=32'h80.
- Simultaneous fetch_start+PCWre in IDLE: pc=32'h8, PCSrc=00 → imem_addr=32'hC; fetch_start during busy issues no second request.
- RST asserted in a cycle with imem_ack=1 → IR=0, ir_valid=0, imem_req=0, pc=RESET_PC.
